// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS control unit: sequences fetch/decode/execute one state per clock
// and decodes every DataPath control input from the current state.
module multicycle_control_fsm #(
    parameter logic [5:0] OP_IN  = 6'h3E,
    parameter logic [5:0] OP_OUT = 6'h3F
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       PCWrite,
    output logic [1:0] PCSrc,
    output logic       RegWrite,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] RegDst,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] gpio_i,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic       final_en,
    output logic       illegal,
    output logic [3:0] state_o
);

    localparam logic [3:0] FETCH  = 4'd0;
    localparam logic [3:0] DECODE = 4'd1;
    localparam logic [3:0] MEMADR = 4'd2;
    localparam logic [3:0] MEMRD  = 4'd3;
    localparam logic [3:0] MEMWB  = 4'd4;
    localparam logic [3:0] MEMWR  = 4'd5;
    localparam logic [3:0] REXEC  = 4'd6;
    localparam logic [3:0] RWB    = 4'd7;
    localparam logic [3:0] IEXEC  = 4'd8;
    localparam logic [3:0] IWB    = 4'd9;
    localparam logic [3:0] BRANCH = 4'd10;
    localparam logic [3:0] JUMP   = 4'd11;
    localparam logic [3:0] JAL    = 4'd12;
    localparam logic [3:0] JALWB  = 4'd13;
    localparam logic [3:0] JR     = 4'd14;
    localparam logic [3:0] OUTWB  = 4'd15;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    logic [3:0] state, next_state;

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= next_state;
    end

    assign state_o = reset ? 4'd0 : state;

    // Decode is suppressed entirely while reset is high so no strobe can fire.
    always_comb begin
        next_state = FETCH;
        PCWrite    = 1'b0;
        PCSrc      = 2'd0;
        RegWrite   = 1'b0;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 2'd0;
        MemtoReg   = 1'b0;
        ALUSrcA    = 1'b0;
        gpio_i     = 2'd0;
        ALUSrcB    = 2'd0;
        ALUControl = ALU_AND;
        final_en   = 1'b0;
        illegal    = 1'b0;
        if (!reset) begin
            case (state)
                FETCH: begin
                    IRWrite = 1'b1; ALUSrcB = 2'd1; ALUControl = ALU_ADD;
                    PCWrite = 1'b1; next_state = DECODE;
                end
                DECODE: begin
                    ALUSrcB = 2'd3; gpio_i = 2'd1; ALUControl = ALU_ADD;
                    case (Op)
                        6'h23, 6'h2B: next_state = MEMADR;
                        6'h00: begin
                            if (Funct == 6'h08)
                                next_state = JR;
                            else if (Funct == 6'h20 || Funct == 6'h22 || Funct == 6'h24 ||
                                     Funct == 6'h25 || Funct == 6'h2A)
                                next_state = REXEC;
                            else
                                illegal = 1'b1;
                        end
                        6'h08, 6'h0D, 6'h0F, OP_IN, OP_OUT: next_state = IEXEC;
                        6'h04, 6'h05: next_state = BRANCH;
                        6'h02: next_state = JUMP;
                        6'h03: next_state = JAL;
                        default: illegal = 1'b1;
                    endcase
                end
                MEMADR: begin
                    ALUSrcA = 1'b1; ALUSrcB = 2'd2; gpio_i = 2'd1; ALUControl = ALU_ADD;
                    next_state = (Op == 6'h2B) ? MEMWR : MEMRD;
                end
                MEMRD: begin
                    IorD = 1'b1; next_state = MEMWB;
                end
                MEMWB: begin
                    MemtoReg = 1'b1; RegWrite = 1'b1;
                end
                MEMWR: begin
                    IorD = 1'b1; MemWrite = 1'b1;
                end
                REXEC: begin
                    ALUSrcA = 1'b1; next_state = RWB;
                    case (Funct)
                        6'h22:   ALUControl = ALU_SUB;
                        6'h24:   ALUControl = ALU_AND;
                        6'h25:   ALUControl = ALU_OR;
                        6'h2A:   ALUControl = ALU_SLT;
                        default: ALUControl = ALU_ADD;
                    endcase
                end
                RWB: begin
                    RegDst = 2'd1; RegWrite = 1'b1;
                end
                IEXEC: begin
                    ALUSrcA = 1'b1; ALUSrcB = 2'd2;
                    ALUControl = (Op == 6'h0D) ? ALU_OR : ALU_ADD;
                    // ori deliberately shares the sign-extended immediate path
                    if (Op == 6'h0F)        gpio_i = 2'd0;
                    else if (Op == OP_IN)   gpio_i = 2'd2;
                    else if (Op == OP_OUT)  gpio_i = 2'd3;
                    else                    gpio_i = 2'd1;
                    next_state = (Op == OP_OUT) ? OUTWB : IWB;
                end
                IWB: begin
                    RegWrite = 1'b1;
                end
                OUTWB: begin
                    final_en = 1'b1;
                end
                BRANCH: begin
                    ALUSrcA = 1'b1; ALUControl = ALU_SUB; PCSrc = 2'd1;
                    PCWrite = (Op == 6'h05) ? !Zero : Zero;
                end
                JUMP: begin
                    PCSrc = 2'd2; PCWrite = 1'b1;
                end
                JAL: begin
                    ALUSrcB = 2'd2; gpio_i = 2'd3; ALUControl = ALU_ADD;
                    PCSrc = 2'd2; PCWrite = 1'b1; next_state = JALWB;
                end
                JALWB: begin
                    RegDst = 2'd2; RegWrite = 1'b1;
                end
                JR: begin
                    ALUSrcA = 1'b1; ALUSrcB = 2'd2; gpio_i = 2'd3; ALUControl = ALU_ADD;
                    PCWrite = 1'b1;
                end
                default: next_state = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks each instruction class through
// its state sequence and compares the decoded controls with hand-derived values.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       PCWrite;
    logic [1:0] PCSrc;
    logic       RegWrite;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] RegDst;
    logic       MemtoReg;
    logic       ALUSrcA;
    logic [1:0] gpio_i;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic       final_en;
    logic       illegal;
    logic [3:0] state_o;

    int checks = 0;
    int errors = 0;

    multicycle_control_fsm dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
        .PCWrite(PCWrite), .PCSrc(PCSrc), .RegWrite(RegWrite), .IorD(IorD),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .ALUSrcA(ALUSrcA), .gpio_i(gpio_i), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
        .final_en(final_en), .illegal(illegal), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [25:0] all_out;
        Op = 6'h00; Funct = 6'h20; Zero = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (state_o !== 4'd0 || IRWrite !== 1'b1) begin
            errors++; $display("FAIL reset_fetch: state_o=%0d IRWrite=%b required 0/1", state_o, IRWrite);
        end
        step(); step();
        checks++;
        if (state_o !== 4'd6) begin
            errors++; $display("FAIL reach_rexec: state_o=%0d required 6", state_o);
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            all_out = {PCWrite, PCSrc, RegWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg,
                       ALUSrcA, gpio_i, ALUSrcB, ALUControl, final_en, illegal, state_o};
            checks++;
            if (all_out !== 26'd0) begin
                errors++; $display("FAIL reset_outputs_%0d: outputs=%h required 0", i, all_out);
            end
            if (i < 2) step();
        end
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (state_o !== 4'd0 || IRWrite !== 1'b1 || PCWrite !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: state_o=%0d IRWrite=%b PCWrite=%b required 0/1/1",
                     state_o, IRWrite, PCWrite);
        end
    endtask

    task automatic test_lw();
        logic [3:0] exp_s [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        Op = 6'h23; Funct = 6'h00;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (state_o !== exp_s[i] || MemWrite !== 1'b0 ||
                (RegWrite && MemtoReg) !== (exp_s[i] == 4'd4)) begin
                errors++;
                $display("FAIL lw_cycle_%0d: state_o=%0d MemWrite=%b RegWrite=%b MemtoReg=%b required state %0d",
                         i, state_o, MemWrite, RegWrite, MemtoReg, exp_s[i]);
            end
            if (exp_s[i] == 4'd3) begin
                checks++;
                if (IorD !== 1'b1) begin
                    errors++; $display("FAIL lw_memrd_iord: IorD=%b required 1", IorD);
                end
            end
            step();
        end
        checks++;
        if (state_o !== 4'd0) begin
            errors++; $display("FAIL lw_return: state_o=%0d required 0", state_o);
        end
    endtask

    task automatic test_sw();
        Op = 6'h2B;
        step(); step();
        checks++;
        if (state_o !== 4'd2 || ALUSrcA !== 1'b1 || ALUSrcB !== 2'd2 || gpio_i !== 2'd1) begin
            errors++; $display("FAIL sw_memadr: state_o=%0d ALUSrcA=%b ALUSrcB=%0d gpio_i=%0d required 2/1/2/1",
                               state_o, ALUSrcA, ALUSrcB, gpio_i);
        end
        step();
        checks++;
        if (state_o !== 4'd5 || MemWrite !== 1'b1 || IorD !== 1'b1 || RegWrite !== 1'b0) begin
            errors++; $display("FAIL sw_memwr: state_o=%0d MemWrite=%b IorD=%b RegWrite=%b required 5/1/1/0",
                               state_o, MemWrite, IorD, RegWrite);
        end
        step();
        checks++;
        if (state_o !== 4'd0) begin
            errors++; $display("FAIL sw_return: state_o=%0d required 0", state_o);
        end
    endtask

    task automatic test_rtype();
        Op = 6'h00; Funct = 6'h2A;
        step();
        checks++;
        if (state_o !== 4'd1 || ALUSrcB !== 2'd3 || gpio_i !== 2'd1 || ALUControl !== 3'b010) begin
            errors++; $display("FAIL decode_outputs: state_o=%0d ALUSrcB=%0d gpio_i=%0d ALUControl=%b",
                               state_o, ALUSrcB, gpio_i, ALUControl);
        end
        step();
        checks++;
        if (state_o !== 4'd6 || ALUControl !== 3'b111 || ALUSrcA !== 1'b1 || ALUSrcB !== 2'd0) begin
            errors++; $display("FAIL slt_rexec: state_o=%0d ALUControl=%b ALUSrcA=%b required 6/111/1",
                               state_o, ALUControl, ALUSrcA);
        end
        step();
        checks++;
        if (state_o !== 4'd7 || RegDst !== 2'd1 || RegWrite !== 1'b1 || MemtoReg !== 1'b0) begin
            errors++; $display("FAIL slt_rwb: state_o=%0d RegDst=%0d RegWrite=%b required 7/1/1",
                               state_o, RegDst, RegWrite);
        end
        step();
        Funct = 6'h22;
        step(); step();
        checks++;
        if (state_o !== 4'd6 || ALUControl !== 3'b110) begin
            errors++; $display("FAIL sub_rexec: state_o=%0d ALUControl=%b required 6/110", state_o, ALUControl);
        end
        step(); step();
        Funct = 6'h25;
        step(); step();
        checks++;
        if (ALUControl !== 3'b001) begin
            errors++; $display("FAIL or_rexec: ALUControl=%b required 001", ALUControl);
        end
        step(); step();
        Funct = 6'h08;
        step(); step();
        checks++;
        if (state_o !== 4'd14 || PCSrc !== 2'd0 || PCWrite !== 1'b1 || gpio_i !== 2'd3 || ALUSrcA !== 1'b1) begin
            errors++; $display("FAIL jr_state: state_o=%0d PCSrc=%0d PCWrite=%b gpio_i=%0d required 14/0/1/3",
                               state_o, PCSrc, PCWrite, gpio_i);
        end
        step();
        checks++;
        if (state_o !== 4'd0) begin
            errors++; $display("FAIL jr_return: state_o=%0d required 0", state_o);
        end
    endtask

    task automatic test_branch();
        logic [5:0] ops   [4] = '{6'h04, 6'h04, 6'h05, 6'h05};
        logic       zeros [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic       exp_w [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            Op = ops[i]; Zero = zeros[i];
            step(); step();
            checks++;
            if (state_o !== 4'd10 || PCWrite !== exp_w[i] || PCSrc !== 2'd1 || ALUControl !== 3'b110) begin
                errors++;
                $display("FAIL branch_%0d: state_o=%0d PCWrite=%b PCSrc=%0d ALUControl=%b required 10/%b/1/110",
                         i, state_o, PCWrite, PCSrc, ALUControl, exp_w[i]);
            end
            step();
            checks++;
            if (state_o !== 4'd0) begin
                errors++; $display("FAIL branch_return_%0d: state_o=%0d required 0", i, state_o);
            end
        end
        Zero = 1'b0;
    endtask

    task automatic test_jumps();
        Op = 6'h02;
        step(); step();
        checks++;
        if (state_o !== 4'd11 || PCSrc !== 2'd2 || PCWrite !== 1'b1) begin
            errors++; $display("FAIL j_state: state_o=%0d PCSrc=%0d PCWrite=%b required 11/2/1",
                               state_o, PCSrc, PCWrite);
        end
        step();
        Op = 6'h03;
        step(); step();
        checks++;
        if (state_o !== 4'd12 || PCSrc !== 2'd2 || PCWrite !== 1'b1 || gpio_i !== 2'd3 || ALUSrcB !== 2'd2) begin
            errors++; $display("FAIL jal_state: state_o=%0d PCSrc=%0d PCWrite=%b gpio_i=%0d required 12/2/1/3",
                               state_o, PCSrc, PCWrite, gpio_i);
        end
        step();
        checks++;
        if (state_o !== 4'd13 || RegDst !== 2'd2 || RegWrite !== 1'b1 || PCWrite !== 1'b0) begin
            errors++; $display("FAIL jalwb_state: state_o=%0d RegDst=%0d RegWrite=%b required 13/2/1",
                               state_o, RegDst, RegWrite);
        end
        step();
        checks++;
        if (state_o !== 4'd0) begin
            errors++; $display("FAIL jal_return: state_o=%0d required 0", state_o);
        end
    endtask

    task automatic test_immediate_io();
        logic [5:0] ops   [4] = '{6'h08, 6'h0D, 6'h0F, 6'h3E};
        logic [1:0] exp_g [4] = '{2'd1, 2'd1, 2'd0, 2'd2};
        logic [2:0] exp_a [4] = '{3'b010, 3'b001, 3'b010, 3'b010};
        for (int i = 0; i < 4; i++) begin
            Op = ops[i];
            step(); step();
            checks++;
            if (state_o !== 4'd8 || gpio_i !== exp_g[i] || ALUControl !== exp_a[i] || ALUSrcB !== 2'd2) begin
                errors++;
                $display("FAIL iexec_%0d: state_o=%0d gpio_i=%0d ALUControl=%b required 8/%0d/%b",
                         i, state_o, gpio_i, ALUControl, exp_g[i], exp_a[i]);
            end
            step();
            checks++;
            if (state_o !== 4'd9 || RegWrite !== 1'b1 || RegDst !== 2'd0 || final_en !== 1'b0) begin
                errors++; $display("FAIL iwb_%0d: state_o=%0d RegWrite=%b RegDst=%0d required 9/1/0",
                                   i, state_o, RegWrite, RegDst);
            end
            step();
        end
        Op = 6'h3F;
        step(); step();
        checks++;
        if (state_o !== 4'd8 || gpio_i !== 2'd3 || ALUControl !== 3'b010) begin
            errors++; $display("FAIL out_iexec: state_o=%0d gpio_i=%0d required 8/3", state_o, gpio_i);
        end
        step();
        checks++;
        if (state_o !== 4'd15 || final_en !== 1'b1 || RegWrite !== 1'b0) begin
            errors++; $display("FAIL out_final: state_o=%0d final=%b required 15/1", state_o, final_en);
        end
        step();
        checks++;
        if (state_o !== 4'd0 || final_en !== 1'b0) begin
            errors++; $display("FAIL out_final_drop: state_o=%0d final=%b required 0/0", state_o, final_en);
        end
    endtask

    task automatic test_illegal();
        checks++;
        if (illegal !== 1'b0) begin
            errors++; $display("FAIL illegal_idle: illegal=%b required 0", illegal);
        end
        Op = 6'h3A;
        step();
        checks++;
        if (state_o !== 4'd1 || illegal !== 1'b1) begin
            errors++; $display("FAIL illegal_pulse: state_o=%0d illegal=%b required 1/1", state_o, illegal);
        end
        step();
        checks++;
        if (state_o !== 4'd0 || illegal !== 1'b0) begin
            errors++; $display("FAIL illegal_return: state_o=%0d illegal=%b required 0/0", state_o, illegal);
        end
        Op = 6'h00; Funct = 6'h3F;
        step();
        checks++;
        if (illegal !== 1'b1) begin
            errors++; $display("FAIL illegal_funct: illegal=%b required 1", illegal);
        end
        step();
        checks++;
        if (state_o !== 4'd0) begin
            errors++; $display("FAIL illegal_funct_return: state_o=%0d required 0", state_o);
        end
    endtask

    task automatic test_back_to_back();
        Op = 6'h0D;
        for (int i = 0; i < 3; i++) begin
            step(); step(); step(); step();
            checks++;
            if (state_o !== 4'd0 || IRWrite !== 1'b1 || RegWrite !== 1'b0) begin
                errors++; $display("FAIL b2b_fetch_%0d: state_o=%0d IRWrite=%b required 0/1", i, state_o, IRWrite);
            end
        end
    endtask

    initial begin
        reset = 1'b1; Op = 6'h00; Funct = 6'h00; Zero = 1'b0;
        test_reset();
        test_lw();
        test_sw();
        test_rtype();
        test_branch();
        test_jumps();
        test_immediate_io();
        test_illegal();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
